// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller for a two-operand, 16-bit calculator.
// Collects operands A and B digit by digit, stores the operator and latches R = A op B on EXE.
module keypad_entry_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  val,
  input  logic        sel,
  input  logic        dec_mode,
  output logic        restriction,
  output logic [15:0] display,
  output logic [4:0]  op_code,
  output logic [1:0]  state,
  output logic        result_valid
);

  typedef enum logic [1:0] {
    StEnterA     = 2'd0,
    StEnterB     = 2'd1,
    StShowResult = 2'd2,
    StInvalid    = 2'd3
  } state_e;

  localparam logic [4:0] KeyAdd  = 5'h10;
  localparam logic [4:0] KeyMult = 5'h11;
  localparam logic [4:0] KeyAnd  = 5'h12;
  localparam logic [4:0] KeyExe  = 5'h13;
  localparam logic [4:0] KeySub  = 5'h14;
  localparam logic [4:0] KeyOr   = 5'h15;
  localparam logic [4:0] KeyCe   = 5'h16;
  localparam logic [4:0] KeyClr  = 5'h17;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, r_q, r_d, display_q, display_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic        rv_q, rv_d;

  logic        is_digit, is_op, digit_room;
  logic [15:0] alu_res;
  logic [31:0] product;

  function automatic logic [15:0] apply_digit(input logic [15:0] x, input logic [3:0] d,
                                              input logic dec);
    if (dec) begin
      // x*10 + d, truncated to 16 bits
      return {x[12:0], 3'b000} + {x[14:0], 1'b0} + {12'h000, d};
    end
    return {x[11:0], d};
  endfunction

  assign is_digit   = ~val[4] & ~(dec_mode & (val[3:0] > 4'd9));
  assign is_op      = (val == KeyAdd) || (val == KeyMult) || (val == KeyAnd) ||
                      (val == KeySub) || (val == KeyOr);
  assign digit_room = (cnt_q != 3'd4);
  assign product    = 32'(a_q) * 32'(b_q);

  always_comb begin
    alu_res = 16'h0000;
    case (op_q)
      KeyAdd:  alu_res = a_q + b_q;
      KeyMult: alu_res = product[15:0];
      KeyAnd:  alu_res = a_q & b_q;
      KeySub:  alu_res = a_q - b_q;
      KeyOr:   alu_res = a_q | b_q;
      default: alu_res = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rv_d    = 1'b0;

    if (state_q == StInvalid || (sel && val == KeyClr)) begin
      state_d = StEnterA;
      a_d     = 16'h0000;
      b_d     = 16'h0000;
      r_d     = 16'h0000;
      cnt_d   = 3'd0;
      op_d    = 5'h00;
    end else if (sel) begin
      case (state_q)
        StEnterA: begin
          if (is_digit && digit_room) begin
            a_d   = apply_digit(a_q, val[3:0], dec_mode);
            cnt_d = cnt_q + 3'd1;
          end else if (is_op) begin
            op_d    = val;
            cnt_d   = 3'd0;
            b_d     = 16'h0000;
            state_d = StEnterB;
          end else if (val == KeyCe) begin
            a_d   = 16'h0000;
            cnt_d = 3'd0;
          end
        end
        StEnterB: begin
          if (is_digit && digit_room) begin
            b_d   = apply_digit(b_q, val[3:0], dec_mode);
            cnt_d = cnt_q + 3'd1;
          end else if (is_op && cnt_q == 3'd0) begin
            op_d = val;
          end else if (val == KeyExe) begin
            r_d     = alu_res;
            rv_d    = 1'b1;
            state_d = StShowResult;
          end else if (val == KeyCe) begin
            b_d   = 16'h0000;
            cnt_d = 3'd0;
          end
        end
        StShowResult: begin
          if (is_digit) begin
            a_d     = {12'h000, val[3:0]};
            cnt_d   = 3'd1;
            op_d    = 5'h00;
            state_d = StEnterA;
          end else if (is_op) begin
            a_d     = r_q;
            op_d    = val;
            b_d     = 16'h0000;
            cnt_d   = 3'd0;
            state_d = StEnterB;
          end else if (val == KeyCe) begin
            state_d = StEnterA;
            a_d     = 16'h0000;
            b_d     = 16'h0000;
            r_d     = 16'h0000;
            cnt_d   = 3'd0;
            op_d    = 5'h00;
          end
        end
        default: state_d = StEnterA;
      endcase
    end

    // Display is registered from next-state values so it tracks state with no extra lag.
    case (state_d)
      StEnterA:     display_d = a_d;
      StEnterB:     display_d = b_d;
      StShowResult: display_d = r_d;
      default:      display_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEnterA;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      r_q       <= 16'h0000;
      cnt_q     <= 3'd0;
      op_q      <= 5'h00;
      rv_q      <= 1'b0;
      display_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rv_q      <= rv_d;
      display_q <= display_d;
    end
  end

  assign restriction  = dec_mode;
  assign display      = display_q;
  assign op_code      = op_q;
  assign state        = state_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: expected outputs are queued with each step and
// popped for comparison one cycle later.
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  val = 5'h1f;
  logic        sel = 1'b0;
  logic        dec_mode = 1'b0;
  logic        restriction;
  logic [15:0] display;
  logic [4:0]  op_code;
  logic [1:0]  state;
  logic        result_valid;

  typedef struct packed {
    logic [15:0] disp;
    logic [4:0]  op;
    logic [1:0]  st;
    logic        rv;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  keypad_entry_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .val          (val),
    .sel          (sel),
    .dec_mode     (dec_mode),
    .restriction  (restriction),
    .display      (display),
    .op_code      (op_code),
    .state        (state),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; outputs sampled #1 after the edge and checked against the queue.
  task automatic step(input logic s, input logic [4:0] v, input logic r, input logic [15:0] ed,
                      input logic [4:0] eo, input logic [1:0] es, input logic erv,
                      input string tag);
    exp_t e, got;
    string t;
    sb.push_back({ed, eo, es, erv});
    tags.push_back(tag);
    @(negedge clk);
    sel = s;
    val = v;
    rst = r;
    @(posedge clk);
    #1;
    sel = 1'b0;
    rst = 1'b0;
    e   = sb.pop_front();
    t   = tags.pop_front();
    got = {display, op_code, state, result_valid};
    n_checks++;
    assert (got === e) else begin
      n_fails++;
      $error("FAIL %s: observed disp=%h op=%h st=%0d rv=%b expected disp=%h op=%h st=%0d rv=%b",
             t, got.disp, got.op, got.st, got.rv, e.disp, e.op, e.st, e.rv);
    end
  endtask

  task automatic press(input logic [4:0] v, input logic [15:0] ed, input logic [4:0] eo,
                       input logic [1:0] es, input logic erv, input string tag);
    step(1'b1, v, 1'b0, ed, eo, es, erv, tag);
  endtask

  task automatic check_restriction(input logic exp_r);
    #1;
    n_checks++;
    assert (restriction === exp_r) else begin
      n_fails++;
      $error("FAIL restriction: observed %b expected %b", restriction, exp_r);
    end
  endtask

  initial begin
    step(1'b0, 5'h1f, 1'b1, 16'h0000, 5'h00, 2'd0, 1'b0, "reset");
    check_restriction(1'b0);

    // Hex add
    press(5'h01, 16'h0001, 5'h00, 2'd0, 1'b0, "hex_a1");
    press(5'h02, 16'h0012, 5'h00, 2'd0, 1'b0, "hex_a2");
    press(5'h10, 16'h0000, 5'h10, 2'd1, 1'b0, "hex_add");
    press(5'h03, 16'h0003, 5'h10, 2'd1, 1'b0, "hex_b3");
    press(5'h13, 16'h0015, 5'h10, 2'd2, 1'b1, "hex_exe");
    val = 5'h03;
    step(1'b0, 5'h03, 1'b0, 16'h0015, 5'h10, 2'd2, 1'b0, "rv_drop_sel0");
    press(5'h1f, 16'h0015, 5'h10, 2'd2, 1'b0, "none_key");
    press(5'h18, 16'h0015, 5'h10, 2'd2, 1'b0, "undef_key");
    press(5'h13, 16'h0015, 5'h10, 2'd2, 1'b0, "exe_in_result");
    press(5'h17, 16'h0000, 5'h00, 2'd0, 1'b0, "clr");

    // Decimal saturation at four digits
    dec_mode = 1'b1;
    check_restriction(1'b1);
    press(5'h09, 16'd9,    5'h00, 2'd0, 1'b0, "dec_9");
    press(5'h09, 16'd99,   5'h00, 2'd0, 1'b0, "dec_99");
    press(5'h09, 16'd999,  5'h00, 2'd0, 1'b0, "dec_999");
    press(5'h09, 16'd9999, 5'h00, 2'd0, 1'b0, "dec_9999");
    press(5'h09, 16'd9999, 5'h00, 2'd0, 1'b0, "dec_5th");
    press(5'h0a, 16'd9999, 5'h00, 2'd0, 1'b0, "dec_hexdigit");
    press(5'h16, 16'h0000, 5'h00, 2'd0, 1'b0, "ce_a");
    press(5'h0c, 16'h0000, 5'h00, 2'd0, 1'b0, "dec_c_ignored");
    dec_mode = 1'b0;

    // Subtract wrap, then chained multiply wrap
    press(5'h14, 16'h0000, 5'h14, 2'd1, 1'b0, "sub");
    press(5'h01, 16'h0001, 5'h14, 2'd1, 1'b0, "sub_b1");
    press(5'h13, 16'hffff, 5'h14, 2'd2, 1'b1, "sub_wrap");
    press(5'h11, 16'h0000, 5'h11, 2'd1, 1'b0, "chain_mult");
    press(5'h0f, 16'h000f, 5'h11, 2'd1, 1'b0, "b_f");
    press(5'h0f, 16'h00ff, 5'h11, 2'd1, 1'b0, "b_ff");
    press(5'h0f, 16'h0fff, 5'h11, 2'd1, 1'b0, "b_fff");
    press(5'h0f, 16'hffff, 5'h11, 2'd1, 1'b0, "b_ffff");
    press(5'h13, 16'h0001, 5'h11, 2'd2, 1'b1, "mult_wrap");

    // New entry from result, chaining, operator replacement
    press(5'h02, 16'h0002, 5'h00, 2'd0, 1'b0, "digit_from_result");
    press(5'h10, 16'h0000, 5'h10, 2'd1, 1'b0, "add2");
    press(5'h03, 16'h0003, 5'h10, 2'd1, 1'b0, "b3");
    press(5'h13, 16'h0005, 5'h10, 2'd2, 1'b1, "sum5");
    press(5'h11, 16'h0000, 5'h11, 2'd1, 1'b0, "chain_mult4");
    press(5'h04, 16'h0004, 5'h11, 2'd1, 1'b0, "b4");
    press(5'h13, 16'h0014, 5'h11, 2'd2, 1'b1, "prod20");
    press(5'h10, 16'h0000, 5'h10, 2'd1, 1'b0, "chain_add");
    press(5'h15, 16'h0000, 5'h15, 2'd1, 1'b0, "op_replace_or");
    press(5'h03, 16'h0003, 5'h15, 2'd1, 1'b0, "or_b3");
    press(5'h12, 16'h0003, 5'h15, 2'd1, 1'b0, "op_after_digit");
    press(5'h13, 16'h0017, 5'h15, 2'd2, 1'b1, "or_result");
    press(5'h16, 16'h0000, 5'h00, 2'd0, 1'b0, "ce_in_result");

    // CE in ENTER_B keeps op
    press(5'h01, 16'h0001, 5'h00, 2'd0, 1'b0, "ce_a1");
    press(5'h10, 16'h0000, 5'h10, 2'd1, 1'b0, "ce_add");
    press(5'h07, 16'h0007, 5'h10, 2'd1, 1'b0, "ce_b7");
    press(5'h16, 16'h0000, 5'h10, 2'd1, 1'b0, "ce_b");
    press(5'h02, 16'h0002, 5'h10, 2'd1, 1'b0, "ce_b2");
    press(5'h13, 16'h0003, 5'h10, 2'd2, 1'b1, "ce_result3");

    // AND and four-digit hex limit
    press(5'h17, 16'h0000, 5'h00, 2'd0, 1'b0, "clr2");
    press(5'h0c, 16'h000c, 5'h00, 2'd0, 1'b0, "and_ac");
    press(5'h12, 16'h0000, 5'h12, 2'd1, 1'b0, "and_op");
    press(5'h0a, 16'h000a, 5'h12, 2'd1, 1'b0, "and_ba");
    press(5'h13, 16'h0008, 5'h12, 2'd2, 1'b1, "and_result");
    press(5'h17, 16'h0000, 5'h00, 2'd0, 1'b0, "clr3");
    press(5'h01, 16'h0001, 5'h00, 2'd0, 1'b0, "h1");
    press(5'h02, 16'h0012, 5'h00, 2'd0, 1'b0, "h12");
    press(5'h03, 16'h0123, 5'h00, 2'd0, 1'b0, "h123");
    press(5'h04, 16'h1234, 5'h00, 2'd0, 1'b0, "h1234");
    press(5'h05, 16'h1234, 5'h00, 2'd0, 1'b0, "h_5th");

    // Reset wins over a simultaneous press in ENTER_B
    press(5'h10, 16'h0000, 5'h10, 2'd1, 1'b0, "pre_rst_op");
    press(5'h06, 16'h0006, 5'h10, 2'd1, 1'b0, "pre_rst_b");
    step(1'b1, 5'h05, 1'b1, 16'h0000, 5'h00, 2'd0, 1'b0, "rst_with_press");
    press(5'h05, 16'h0005, 5'h00, 2'd0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 16 bits.
REQ-002 clk  input  1  Single system clock, the same clock as the VGA/cursor logic; all state changes on its rising edge.
REQ-003 rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 val  input  5  Key code from the cursor: 0x00-0x0F digit, 0x10 add, 0x11 mult, 0x12 and, 0x13 EXE, 0x14 sub, 0x15 or, 0x16 CE, 0x17 CLR, 0x1F or any other code = none.
REQ-005 sel  input  1  Key-press pulse; every cycle in which sel is high is one press of the current val.
REQ-006 dec_mode  input  1  1 = decimal entry, 0 = hex entry.
REQ-007 restriction  output  1  Equals dec_mode (combinational); drives the cursor's forbidden-zone input.
REQ-008 display  output  16  Value being shown: the operand under entry, or the result.
REQ-009 op_code  output  5  Stored operator code; 0x00 when no operator is stored.
REQ-010 state  output  2  0 = ENTER_A, 1 = ENTER_B, 2 = SHOW_RESULT; 3 is unused.
REQ-011 result_valid  output  1  One-cycle pulse in the cycle after a result has been latched.

Function
REQ-012 Registers: A, B, R (16 b each); cnt (3 b, digits entered in the current operand); op (5 b); state.
REQ-013 All outputs except restriction SHALL be registered; a press sampled at edge n is visible after edge n.
REQ-014 Presses with sel=0, an undefined val, or 0x1F SHALL cause no change.
REQ-015 In dec_mode, digits 0xA-0xF SHALL be ignored.
REQ-016 Digit entry SHALL be hex: X <= {X[11:0], d}; dec: X <= X*10 + d, truncated to 16 b.
REQ-017 Digit entry SHALL increment cnt; when cnt == 4, further digits SHALL be ignored, so the dec maximum is 9999.
REQ-018 A change of dec_mode SHALL take effect at the next press and SHALL NOT clear any register.
REQ-019 ENTER_A: digit -> entered into A.
REQ-020 ENTER_A: operator -> op stored, cnt = 0, B = 0, next state ENTER_B.
REQ-021 ENTER_A: EXE -> ignored.
REQ-022 ENTER_A: CE -> A = 0, cnt = 0.
REQ-023 ENTER_B: digit -> entered into B.
REQ-024 ENTER_B: operator with cnt == 0 -> replaces op; operator with cnt > 0 -> ignored.
REQ-025 ENTER_B: EXE -> R = A op B, next state SHOW_RESULT, result_valid = 1 for exactly one cycle.
REQ-026 ENTER_B: CE -> B = 0, cnt = 0, op kept.
REQ-027 SHOW_RESULT: digit -> A = 0 with the digit applied, cnt = 1, op = 0, next state ENTER_A.
REQ-028 SHOW_RESULT: operator -> A = R, op stored, B = 0, cnt = 0, next state ENTER_B (chaining).
REQ-029 SHOW_RESULT: EXE -> ignored.
REQ-030 SHOW_RESULT: CE -> same as CLR.
REQ-031 CLR in any state SHALL give the reset values in the next cycle.
REQ-032 Arithmetic SHALL be modulo 2^16: add wraps; sub = A - B two's-complement wrap; mult keeps the low 16 b of the 32 b product; and/or are bitwise.
REQ-033 display SHALL equal A in ENTER_A, B in ENTER_B, and R in SHOW_RESULT.
REQ-034 State 3, if reached, SHALL return to ENTER_A with reset values on the next edge.

Reset
REQ-035 While rst=1, sel SHALL be ignored; rst has priority over any simultaneous press.
REQ-036 Reset values SHALL be: A = B = R = 0, cnt = 0, op = 0x00, state = ENTER_A, display = 0, result_valid = 0.
REQ-037 A reset in the middle of an operation SHALL discard all partial entry.

Verification
REQ-038 Hex: press 1, 2, add (0x10), 3, EXE (0x13) -> display 0x0015, state 2, result_valid high for 1 cycle.
REQ-039 Dec: press 9, 9, 9, 9, 9 -> display 9999 (0x270F); then press digit 0xA -> no change.
REQ-040 Wrap: A = 0x0000, sub (0x14), B = 0x0001, EXE -> 0xFFFF; FFFF mult (0x11) FFFF -> 0x0001.
REQ-041 Chain: 2 add 3 EXE, then mult 4 EXE -> 0x0014; operator pressed twice (add then or) before any B digit -> op_code = 0x15.
REQ-042 CE in ENTER_B after 1, add, 7 -> display 0, op_code 0x10; then 2, EXE -> display 3.
REQ-043 rst asserted in the same cycle as sel with val = 5 in ENTER_B -> all outputs at reset values, press ignored.
